secded_mem_ctrl: RTL and testbench
==================================

Name: secded_mem_ctrl

Overview:
Sequencing controller for a SEC-DED protected 8-bit word store. It accepts single read/write requests from one requester. On writes it encodes data into a 13-bit codeword: 8 data bits, 4 Hamming check bits and 1 overall parity bit. On reads it fetches the codeword, computes syndrome and overall parity, corrects single errors, flags double errors and scrubs corrected words back to memory. It sits between the requester and an external synchronous RAM with 1-cycle read latency, and keeps saturating error counters.

Parameters:
ADDR_W, 4, memory address width
CNT_W, 8, width of each error counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse, response complete
rsp_rdata  out  8  read data (corrected when correctable)
rsp_sec  out  1  single error detected and corrected
rsp_ded  out  1  uncorrectable error detected
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  13  codeword to RAM
mem_rdata  in  13  codeword from RAM, valid the cycle after a read strobe
clr_counts  in  1  synchronous clear of both counters
sec_count  out  CNT_W  saturating count of SEC events
ded_count  out  CNT_W  saturating count of DED events

Behaviour:
- Codeword layout: [7:0] = data d; [11:8] = {c8,c4,c2,c1}; [12] = p.
- Check bit equations:
  - c1 = d6^d4^d3^d1^d0
  - c2 = d6^d5^d3^d2^d0
  - c4 = d7^d3^d2^d1
  - c8 = d7^d6^d5^d4
  - p = XOR of d[7:0] and c[3:0]
- Hamming positions: c1=1, c2=2, d0=3, c4=4, d1=5, d2=6, d3=7, c8=8, d4=9, d5=10, d6=11, d7=12.
- Read decode:
  - syn = recomputed check XOR stored check (4 bits).
  - ov = XOR of all 13 stored bits.
- Classification:
  - syn=0, ov=0: clean.
  - syn=0, ov=1: SEC. Parity bit is bad; data is unchanged.
  - syn in 1..12, ov=1: SEC. Flip the bit at position syn.
  - syn≠0, ov=0: DED.
  - syn in 13..15 (any ov): DED.
- FSM states: IDLE, WRITE, READ, CHECK, SCRUB, DONE.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid, latch addr, data and write flag; go to WRITE or READ.
- WRITE: mem_en=1, mem_we=1, mem_wdata = encode(latched data). Next state DONE.
- READ: mem_en=1, mem_we=0. Next state CHECK.
- CHECK:
  - Decode mem_rdata and register rsp_rdata, rsp_sec and rsp_ded.
  - Increment the relevant counter.
  - Next state SCRUB if SEC, else DONE.
- SCRUB: mem_en=1, mem_we=1, mem_wdata = encode(corrected data). Next state DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency from the accept cycle T to rsp_valid:
  - write: T+2
  - clean or DED read: T+3
  - SEC read: T+4
- Memory outputs are combinational from state; mem_en=0 in IDLE, CHECK and DONE.
- Write response: rsp_sec=0, rsp_ded=0, rsp_rdata=0.
- DED response: rsp_rdata = raw stored data bits, no scrub.
- rsp_rdata, rsp_sec and rsp_ded hold until the next CHECK or write DONE.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_counts has priority over a same-cycle increment.
- Reset behaviour:
  - Asserting reset at any point forces IDLE immediately and drops any in-flight operation.
  - Reset values: req_ready=1 after reset release; every other output and register 0, including both counters.
  - A write interrupted by reset is not guaranteed to have reached the RAM.

Test Plan:
- Write addr 3, data 0xA5 → mem_wdata=0x03A5 at T+1, rsp_valid at T+2. Read addr 3 → rsp_rdata=0xA5, sec=0, ded=0 at T+3, no scrub write.
- RAM preloaded 0x03AD (d3 flipped, syn=7) → rsp_rdata=0xA5, rsp_sec=1, SCRUB writes 0x03A5, rsp_valid at T+4, sec_count=1.
- RAM preloaded 0x13A5 (parity bit flipped) → rsp_rdata=0xA5, rsp_sec=1, scrub writes 0x03A5.
- RAM preloaded 0x03A6 (d0 and d1 flipped, syn=6, ov=0) → rsp_rdata=0xA6, rsp_ded=1, no scrub, ded_count=1.
- With CNT_W=2, 5 consecutive SEC reads → sec_count=3. Then clr_counts coincident with a 6th SEC in CHECK → sec_count=0.
- Assert reset during the READ state → mem_en=0 immediately, rsp_valid never pulses, req_ready=1 after release, both counters 0.

Source files
------------

// File: rtl/secded_mem_ctrl.sv
// SEC-DED protected word store controller: encodes writes, corrects/flags reads,
// scrubs corrected words back to RAM and keeps saturating error counters.
module secded_mem_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_sec,
    output logic              rsp_ded,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [12:0]       mem_wdata,
    input  logic [12:0]       mem_rdata,
    input  logic              clr_counts,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_CHECK, S_SCRUB, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;
    logic              r_sec, r_ded;
    logic [CNT_W-1:0]  r_sec_cnt, r_ded_cnt;

    logic [3:0]        w_syn;
    logic              w_ov;
    logic              w_sec, w_ded;
    logic [7:0]        w_data;

    // Returns {c8,c4,c2,c1}
    function automatic logic [3:0] calc_check(input logic [7:0] d);
        calc_check = {d[7] ^ d[6] ^ d[5] ^ d[4],
                      d[7] ^ d[3] ^ d[2] ^ d[1],
                      d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0],
                      d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0]};
    endfunction

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [3:0] c;
        c      = calc_check(d);
        encode = {^{c, d}, c, d};
    endfunction

    // Only data positions matter: check bits are regenerated on scrub
    function automatic logic [7:0] correct(input logic [7:0] d, input logic [3:0] syn);
        logic [7:0] flip;
        flip = 8'h00;
        case (syn)
            4'd3:    flip = 8'h01;
            4'd5:    flip = 8'h02;
            4'd6:    flip = 8'h04;
            4'd7:    flip = 8'h08;
            4'd9:    flip = 8'h10;
            4'd10:   flip = 8'h20;
            4'd11:   flip = 8'h40;
            4'd12:   flip = 8'h80;
            default: flip = 8'h00;
        endcase
        correct = d ^ flip;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        w_syn  = calc_check(mem_rdata[7:0]) ^ mem_rdata[11:8];
        w_ov   = ^mem_rdata;
        w_sec  = w_ov && (w_syn <= 4'd12);
        w_ded  = ((w_syn != 4'd0) && !w_ov) || (w_syn > 4'd12);
        w_data = w_ded ? mem_rdata[7:0] : correct(mem_rdata[7:0], w_syn);
    end

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = req_write ? S_WRITE : S_READ;
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = encode(r_wdata);
                w_next    = S_DONE;
            end
            S_READ: begin
                mem_en   = 1'b1;
                mem_addr = r_addr;
                w_next   = S_CHECK;
            end
            S_CHECK: w_next = w_sec ? S_SCRUB : S_DONE;
            S_SCRUB: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = encode(r_rdata);
                w_next    = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_sec     <= 1'b0;
            r_ded     <= 1'b0;
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // Write responses carry no data or error flags
            if (r_state == S_WRITE) begin
                r_rdata <= '0;
                r_sec   <= 1'b0;
                r_ded   <= 1'b0;
            end
            if (r_state == S_CHECK) begin
                r_rdata <= w_data;
                r_sec   <= w_sec;
                r_ded   <= w_ded;
            end
            if (clr_counts) begin
                r_sec_cnt <= '0;
                r_ded_cnt <= '0;
            end else if (r_state == S_CHECK) begin
                if (w_sec) r_sec_cnt <= sat_inc(r_sec_cnt);
                if (w_ded) r_ded_cnt <= sat_inc(r_ded_cnt);
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_rdata = r_rdata;
    assign rsp_sec   = r_sec;
    assign rsp_ded   = r_ded;
    assign sec_count = r_sec_cnt;
    assign ded_count = r_ded_cnt;

endmodule

// File: tb/tb_secded_mem_ctrl.sv
// Directed table-driven bench for secded_mem_ctrl with a 1-cycle-latency RAM model.
module tb_secded_mem_ctrl;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid, rsp_sec, rsp_ded;
    logic [7:0]        rsp_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [12:0]       mem_wdata;
    logic [12:0]       mem_rdata = '0;
    logic              clr_counts;
    logic [CNT_W-1:0]  sec_count, ded_count;

    secded_mem_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_sec(rsp_sec), .rsp_ded(rsp_ded),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .clr_counts(clr_counts), .sec_count(sec_count), .ded_count(ded_count)
    );

    always #5 clk = ~clk;

    // RAM model plus write monitor; the bench preloads words through pre_*
    logic [12:0]       ram [16];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [12:0]       pre_word = '0;
    int                wr_cnt = 0;
    logic [12:0]       last_word = '0;
    logic [ADDR_W-1:0] last_addr = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_word;
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_word     <= mem_wdata;
            last_addr     <= mem_addr;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        pre;
        logic [12:0] pre_word;
        logic [7:0]  e_rdata;
        logic        e_sec;
        logic        e_ded;
        int          e_lat;
        int          e_nwr;
        logic [12:0] e_wword;
        int          e_scnt;
        int          e_dcnt;
    } vec_t;

    vec_t vec [12];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [12:0] w);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_word = w;
        @(posedge clk);
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk(nm, 32'(req_ready), 32'd1);
    endtask

    // Accept on the next edge; lat counts cycles after the accept cycle until rsp_valid
    task automatic do_req(input logic wr, input logic [3:0] a, input logic [7:0] d, output int lat);
        wait_ready("req_ready_timeout");
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   wr0;
        logic seen;

        //           wr  addr   wdata  pre  pre_word  rdata  sec  ded lat nwr wword    scnt dcnt
        vec[0]  = '{1'b1, 4'h3, 8'hA5, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 2, 1, 13'h03A5, 0, 0};
        vec[1]  = '{1'b0, 4'h3, 8'h00, 1'b0, 13'h0000, 8'hA5, 1'b0, 1'b0, 3, 0, 13'h0000, 0, 0};
        vec[2]  = '{1'b0, 4'h5, 8'h00, 1'b1, 13'h03AD, 8'hA5, 1'b1, 1'b0, 4, 1, 13'h03A5, 1, 0};
        vec[3]  = '{1'b0, 4'h6, 8'h00, 1'b1, 13'h13A5, 8'hA5, 1'b1, 1'b0, 4, 1, 13'h03A5, 2, 0};
        vec[4]  = '{1'b0, 4'h7, 8'h00, 1'b1, 13'h03A6, 8'hA6, 1'b0, 1'b1, 3, 0, 13'h0000, 2, 1};
        vec[5]  = '{1'b1, 4'h0, 8'h00, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 2, 1, 13'h0000, 2, 1};
        vec[6]  = '{1'b1, 4'hF, 8'hFF, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 2, 1, 13'h03FF, 2, 1};
        vec[7]  = '{1'b0, 4'hF, 8'h00, 1'b0, 13'h0000, 8'hFF, 1'b0, 1'b0, 3, 0, 13'h0000, 2, 1};
        vec[8]  = '{1'b0, 4'h9, 8'h00, 1'b1, 13'h0D00, 8'h00, 1'b0, 1'b1, 3, 0, 13'h0000, 2, 2};
        vec[9]  = '{1'b0, 4'hA, 8'h00, 1'b1, 13'h07A5, 8'hA5, 1'b1, 1'b0, 4, 1, 13'h03A5, 3, 2};
        vec[10] = '{1'b0, 4'hB, 8'h00, 1'b1, 13'h0325, 8'hA5, 1'b1, 1'b0, 4, 1, 13'h03A5, 3, 2};
        vec[11] = '{1'b0, 4'hC, 8'h00, 1'b1, 13'h13A5, 8'hA5, 1'b1, 1'b0, 4, 1, 13'h03A5, 3, 2};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        clr_counts = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_en",    32'(mem_en),    32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_sec_count", 32'(sec_count), 32'd0);
        chk("rst_ded_count", 32'(ded_count), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vec[i].pre) preload(vec[i].addr, vec[i].pre_word);
            wr0 = wr_cnt;
            do_req(vec[i].wr, vec[i].addr, vec[i].wdata, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat),       32'(vec[i].e_lat));
            chk($sformatf("v%0d_rdata", i),   32'(rsp_rdata), 32'(vec[i].e_rdata));
            chk($sformatf("v%0d_sec", i),     32'(rsp_sec),   32'(vec[i].e_sec));
            chk($sformatf("v%0d_ded", i),     32'(rsp_ded),   32'(vec[i].e_ded));
            chk($sformatf("v%0d_nwrites", i), 32'(wr_cnt - wr0), 32'(vec[i].e_nwr));
            if (vec[i].e_nwr > 0) begin
                chk($sformatf("v%0d_wword", i), 32'(last_word), 32'(vec[i].e_wword));
                chk($sformatf("v%0d_waddr", i), 32'(last_addr), 32'(vec[i].addr));
            end
            chk($sformatf("v%0d_sec_count", i), 32'(sec_count), 32'(vec[i].e_scnt));
            chk($sformatf("v%0d_ded_count", i), 32'(ded_count), 32'(vec[i].e_dcnt));
        end

        // clr_counts lands in the same cycle as a SEC increment in CHECK
        preload(4'hD, 13'h03AD);
        wait_ready("clr_ready_timeout");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'hD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("clr_read_mem_en", 32'({mem_en, mem_we}), 32'b10);
        @(negedge clk);
        chk("clr_check_mem_en", 32'(mem_en), 32'd0);
        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        chk("clr_sec_count", 32'(sec_count), 32'd0);
        chk("clr_ded_count", 32'(ded_count), 32'd0);
        chk("clr_scrub_we",  32'({mem_en, mem_we}), 32'b11);
        chk("clr_scrub_word", 32'(mem_wdata), 32'h03A5);
        @(negedge clk);
        chk("clr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("clr_rsp_sec",   32'(rsp_sec),   32'd1);
        chk("clr_rsp_rdata", 32'(rsp_rdata), 32'hA5);

        // Build up a nonzero DED count, then reset in the middle of a read
        preload(4'h7, 13'h03A6);
        do_req(1'b0, 4'h7, 8'h00, lat);
        chk("pre_rst_ded_count", 32'(ded_count), 32'd1);
        wait_ready("rst_ready_timeout");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'h3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst_read_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_mem_en",    32'(mem_en),    32'd0);
        chk("rst_async_ded_count", 32'(ded_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("rst_no_rsp_valid",   32'(seen),      32'd0);
        chk("rst_post_req_ready", 32'(req_ready), 32'd1);
        chk("rst_post_sec_count", 32'(sec_count), 32'd0);
        chk("rst_post_ded_count", 32'(ded_count), 32'd0);
        chk("rst_post_rsp_ded",   32'(rsp_ded),   32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
